// File: rtl/ecg_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : ecg_sample_capture
// Brief    : Captures ADC words during the sample phase, after a settling
//            delay, and presents the 2**AVG_LOG2-sample average on a
//            valid/ready register with overrun and abort tracking.
// Revision : 1.0 - initial release
// ============================================================================
module ecg_sample_capture #(
    parameter int DW         = 12,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    state,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_valid,
    output logic [DW-1:0] avg_data,
    output logic          avg_valid,
    input  logic          avg_ready,
    output logic          overrun,
    output logic [7:0]    abort_cnt
);

    localparam int               c_aw          = DW + AVG_LOG2;
    localparam logic [1:0]       c_ph_sample   = 2'b10;
    localparam logic [7:0]       c_settle_last = 8'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [AVG_LOG2-1:0] c_smp_last = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ACCUM  = 3'd2,
        S_DONE   = 3'd3,
        S_WAIT   = 3'd4
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [1:0]          state_q;
    logic [7:0]          settle_q, settle_d;
    logic [AVG_LOG2-1:0] smp_q, smp_d;
    logic [c_aw-1:0]     acc_q, acc_d;
    logic [7:0]          abort_q, abort_d;
    logic [DW-1:0]       avg_data_q, avg_data_d;
    logic                avg_valid_q, avg_valid_d;
    logic                overrun_q, overrun_d;

    logic                w_in_sample;
    logic                w_enter;
    logic                w_abort;
    logic                w_load;
    logic [c_aw-1:0]     w_sum;

    assign w_in_sample = (state == c_ph_sample);
    // state_q resets to the sample code so a window open at reset release is skipped
    assign w_enter     = w_in_sample && (state_q != c_ph_sample);
    assign w_sum       = acc_q + c_aw'(adc_data);

    always_comb begin
        fsm_d    = fsm_q;
        settle_d = settle_q;
        smp_d    = smp_q;
        acc_d    = acc_q;
        w_abort  = 1'b0;
        w_load   = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (w_enter) begin
                    settle_d = 8'd0;
                    smp_d    = '0;
                    acc_d    = '0;
                    if (SETTLE_CYC == 0) begin
                        fsm_d = S_ACCUM;
                    end else begin
                        fsm_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!w_in_sample) begin
                    w_abort = 1'b1;
                end else if (settle_q == c_settle_last) begin
                    fsm_d = S_ACCUM;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_ACCUM: begin
                if (!w_in_sample) begin
                    w_abort = 1'b1;
                end else if (adc_valid) begin
                    if (smp_q == c_smp_last) begin
                        w_load = 1'b1;
                        fsm_d  = S_DONE;
                        acc_d  = '0;
                        smp_d  = '0;
                    end else begin
                        acc_d = w_sum;
                        smp_d = smp_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                fsm_d = w_in_sample ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!w_in_sample) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        if (w_abort) begin
            fsm_d    = S_IDLE;
            acc_d    = '0;
            smp_d    = '0;
            settle_d = 8'd0;
        end
    end

    always_comb begin
        abort_d     = abort_q;
        avg_data_d  = avg_data_q;
        avg_valid_d = avg_valid_q;
        overrun_d   = overrun_q;

        if (w_abort && (abort_q != 8'hFF)) begin
            abort_d = abort_q + 8'd1;
        end

        // A load wins over acceptance; overrun only if the old result was never taken
        if (w_load) begin
            avg_data_d  = w_sum[c_aw-1:AVG_LOG2];
            avg_valid_d = 1'b1;
            if (avg_valid_q && !avg_ready) begin
                overrun_d = 1'b1;
            end
        end else if (avg_valid_q && avg_ready) begin
            avg_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= c_ph_sample;
            settle_q    <= 8'd0;
            smp_q       <= '0;
            acc_q       <= '0;
            abort_q     <= 8'd0;
            avg_data_q  <= '0;
            avg_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state;
            settle_q    <= settle_d;
            smp_q       <= smp_d;
            acc_q       <= acc_d;
            abort_q     <= abort_d;
            avg_data_q  <= avg_data_d;
            avg_valid_q <= avg_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign avg_data  = avg_data_q;
    assign avg_valid = avg_valid_q;
    assign overrun   = overrun_q;
    assign abort_cnt = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_ecg_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecg_sample_capture
// Brief    : Directed self-checking bench for ecg_sample_capture (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecg_sample_capture;

    localparam logic [1:0] PH_D = 2'b00;
    localparam logic [1:0] PH_C = 2'b01;
    localparam logic [1:0] PH_S = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [11:0] avg_data;
    logic        avg_valid;
    logic        avg_ready;
    logic        overrun;
    logic [7:0]  abort_cnt;

    int checks    = 0;
    int failures  = 0;
    int exp_abort = 0;
    int hits;

    always #5 clk = ~clk;

    ecg_sample_capture #(
        .DW        (12),
        .AVG_LOG2  (2),
        .SETTLE_CYC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .avg_data (avg_data),
        .avg_valid(avg_valid),
        .avg_ready(avg_ready),
        .overrun  (overrun),
        .abort_cnt(abort_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge consume them, settle past the edge.
    task automatic cyc(input logic [1:0] st, input logic v, input logic [11:0] d);
        state     = st;
        adc_valid = v;
        adc_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Discharge, charge, then three sample-phase cycles (entry + settle) with junk data.
    task automatic open_window();
        cyc(PH_D, 1'b0, 12'd0);
        cyc(PH_C, 1'b0, 12'd0);
        repeat (3) cyc(PH_S, 1'b1, 12'd500);
    endtask

    task automatic sample(input logic [11:0] d, input int gap);
        repeat (gap) cyc(PH_S, 1'b0, 12'd0);
        cyc(PH_S, 1'b1, d);
    endtask

    initial begin
        rst       = 1'b1;
        state     = PH_D;
        adc_valid = 1'b0;
        adc_data  = 12'd0;
        avg_ready = 1'b1;
        cyc(PH_D, 1'b0, 12'd0);
        cyc(PH_D, 1'b0, 12'd0);
        chk("reset_avg_data", avg_data, 0);
        chk("reset_avg_valid", avg_valid, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_abort_cnt", abort_cnt, 0);
        rst = 1'b0;

        // Basic window: settle samples ignored, (100+102+104+106)/4 = 103
        open_window();
        sample(12'd100, 0);
        sample(12'd102, 0);
        sample(12'd104, 0);
        chk("basic_not_early", avg_valid, 0);
        sample(12'd106, 0);
        chk("basic_valid", avg_valid, 1);
        chk("basic_data", avg_data, 103);
        cyc(PH_S, 1'b0, 12'd0);
        chk("basic_consumed", avg_valid, 0);

        // Full scale and floor
        open_window();
        repeat (4) sample(12'd4095, 0);
        chk("fullscale_data", avg_data, 4095);
        cyc(PH_D, 1'b0, 12'd0);
        open_window();
        sample(12'd1, 0);
        sample(12'd1, 0);
        sample(12'd1, 0);
        sample(12'd2, 0);
        chk("floor_data", avg_data, 1);
        cyc(PH_D, 1'b0, 12'd0);

        // Abort in ACCUM, with a discarded sample on the abort cycle
        open_window();
        sample(12'd10, 0);
        sample(12'd20, 0);
        cyc(PH_D, 1'b1, 12'd30);
        exp_abort = 1;
        chk("abort_cnt_1", abort_cnt, exp_abort);
        chk("abort_no_valid", avg_valid, 0);
        open_window();
        repeat (4) sample(12'd8, 0);
        chk("post_abort_data", avg_data, 8);
        cyc(PH_D, 1'b0, 12'd0);

        // Backpressure: second result overwrites the first
        avg_ready = 1'b0;
        open_window();
        repeat (4) sample(12'd50, 0);
        chk("bp_first_data", avg_data, 50);
        chk("bp_first_overrun", overrun, 0);
        cyc(PH_D, 1'b0, 12'd0);
        open_window();
        repeat (4) sample(12'd60, 0);
        chk("bp_second_data", avg_data, 60);
        chk("bp_second_valid", avg_valid, 1);
        chk("bp_overrun_set", overrun, 1);
        rst = 1'b1;
        cyc(PH_D, 1'b0, 12'd0);
        rst = 1'b0;
        exp_abort = 0;
        chk("bp_overrun_cleared", overrun, 0);

        // Acceptance on the load cycle is not an overrun
        open_window();
        repeat (4) sample(12'd50, 0);
        cyc(PH_D, 1'b0, 12'd0);
        open_window();
        repeat (3) sample(12'd60, 0);
        avg_ready = 1'b1;
        sample(12'd60, 0);
        chk("accload_data", avg_data, 60);
        chk("accload_valid", avg_valid, 1);
        chk("accload_overrun", overrun, 0);
        cyc(PH_D, 1'b0, 12'd0);
        chk("accload_consumed", avg_valid, 0);

        // Sparse valid (every third cycle) and one result per window
        open_window();
        sample(12'd7, 2);
        sample(12'd9, 2);
        sample(12'd11, 2);
        sample(12'd13, 2);
        chk("sparse_data", avg_data, 10);
        hits = 0;
        repeat (8) begin
            cyc(PH_S, 1'b1, 12'd1000);
            if (avg_valid) hits++;
        end
        chk("held_window_single_result", hits, 0);
        chk("held_window_no_abort", abort_cnt, exp_abort);
        cyc(PH_D, 1'b0, 12'd0);

        // Reset mid-ACCUM with nonzero outputs
        avg_ready = 1'b0;
        open_window();
        repeat (4) sample(12'd3, 0);
        chk("pre_rst_data", avg_data, 3);
        cyc(PH_D, 1'b0, 12'd0);
        open_window();
        sample(12'd5, 0);
        cyc(PH_D, 1'b0, 12'd0);
        exp_abort = 1;
        chk("settle_accum_abort", abort_cnt, exp_abort);
        open_window();
        sample(12'd5, 0);
        sample(12'd5, 0);
        rst = 1'b1;
        cyc(PH_S, 1'b1, 12'd5);
        exp_abort = 0;
        chk("rst_avg_data", avg_data, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_abort_cnt", abort_cnt, exp_abort);
        chk("rst_overrun", overrun, 0);

        // Released into an already-open window: nothing captured
        rst       = 1'b0;
        avg_ready = 1'b1;
        hits      = 0;
        repeat (12) begin
            cyc(PH_S, 1'b1, 12'd9);
            if (avg_valid) hits++;
        end
        chk("open_at_release_ignored", hits, 0);
        chk("rst_not_abort", abort_cnt, 0);
        open_window();
        repeat (4) sample(12'd9, 0);
        chk("reentry_data", avg_data, 9);
        cyc(PH_D, 1'b0, 12'd0);

        // Abort counter counts SETTLE aborts and saturates
        repeat (10) begin
            cyc(PH_S, 1'b0, 12'd0);
            cyc(PH_D, 1'b0, 12'd0);
        end
        chk("abort_cnt_10", abort_cnt, 10);
        repeat (250) begin
            cyc(PH_S, 1'b0, 12'd0);
            cyc(PH_D, 1'b0, 12'd0);
        end
        chk("abort_cnt_saturated", abort_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
